// File: rtl/l1_cache_ctrl_if.sv
// CPU-side and memory-side bus bundle for l1_cache_ctrl.
// master = the cache controller, slave = the CPU/memory environment.
interface l1_cache_ctrl_if #(
  parameter int ADDRESSBIT = 16,
  parameter int WORDSIZE   = 8,
  parameter int BLOCKBYTE  = 4
);
  logic                          cpu_req;
  logic                          cpu_wr;
  logic [ADDRESSBIT-1:0]         cpu_addr;
  logic [WORDSIZE-1:0]           cpu_wdata;
  logic [WORDSIZE-1:0]           cpu_rdata;
  logic                          cpu_ready;
  logic [ADDRESSBIT-1:0]         mem_addr;
  logic                          mem_rdwt;
  logic [BLOCKBYTE*WORDSIZE-1:0] mem_wdata;
  logic [BLOCKBYTE*WORDSIZE-1:0] mem_rdata;
  logic                          mem_success;

  modport master (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    output mem_addr, mem_rdwt, mem_wdata,
    input  mem_rdata, mem_success
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    input  mem_addr, mem_rdwt, mem_wdata,
    output mem_rdata, mem_success
  );
endinterface

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 cache controller.
// Misses become whole-block memory reads/writes via rdwt/success.
module l1_cache_ctrl #(
  parameter int ADDRESSBIT = 16,
  parameter int WORDSIZE   = 8,
  parameter int BLOCKBYTE  = 4,
  parameter int NUMLINES   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  l1_cache_ctrl_if.master bus,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int OFFB = $clog2(BLOCKBYTE);
  localparam int IDXB = $clog2(NUMLINES);
  localparam int TAGB = ADDRESSBIT - IDXB - OFFB;
  localparam int BW   = BLOCKBYTE * WORDSIZE;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_ISSUE, WB_WAIT,
    FILL_ISSUE, FILL_WAIT, RESP
  } state_t;

  state_t state_q, state_d;

  logic                  wr_q, wr_d;
  logic [ADDRESSBIT-1:0] addr_q, addr_d;
  logic [WORDSIZE-1:0]   wdata_q, wdata_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic [WORDSIZE-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [ADDRESSBIT-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rdwt_q, mem_rdwt_d;
  logic [BW-1:0]         mem_wdata_q, mem_wdata_d;
  logic [15:0]           hit_q, hit_d;
  logic [15:0]           miss_q, miss_d;
  logic                  armed_q, armed_d;

  logic [NUMLINES-1:0]   valid_q;
  logic [NUMLINES-1:0]   dirty_q;
  logic [TAGB-1:0]       tag_q  [NUMLINES];
  logic [BW-1:0]         data_q [NUMLINES];

  logic                  line_we;
  logic [BW-1:0]         line_d;
  logic                  valid_set;
  logic                  dirty_set;
  logic                  dirty_clr;

  logic [TAGB-1:0]       req_tag;
  logic [IDXB-1:0]       req_idx;
  logic [OFFB-1:0]       req_off;
  logic [BW-1:0]         cur_line;
  logic [TAGB-1:0]       cur_tag;
  logic                  hit;
  logic                  succ;

  function automatic logic [WORDSIZE-1:0] get_word(
    input logic [BW-1:0]   blk,
    input logic [OFFB-1:0] o
  );
    get_word = '0;
    for (int k = 0; k < BLOCKBYTE; k++)
      if (OFFB'(k) == o)
        get_word = blk[k*WORDSIZE +: WORDSIZE];
  endfunction

  function automatic logic [BW-1:0] put_word(
    input logic [BW-1:0]       blk,
    input logic [OFFB-1:0]     o,
    input logic [WORDSIZE-1:0] w
  );
    put_word = blk;
    for (int k = 0; k < BLOCKBYTE; k++)
      if (OFFB'(k) == o)
        put_word[k*WORDSIZE +: WORDSIZE] = w;
  endfunction

  assign req_tag  = addr_q[ADDRESSBIT-1 -: TAGB];
  assign req_idx  = addr_q[OFFB +: IDXB];
  assign req_off  = addr_q[OFFB-1:0];
  assign cur_line = data_q[req_idx];
  assign cur_tag  = tag_q[req_idx];
  assign hit      = valid_q[req_idx] && (cur_tag == req_tag);
  // success in the first wait cycle may belong to the previous access
  assign succ     = bus.mem_success && armed_q;

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rdwt  = mem_rdwt_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

  // Next-state, response and memory-request logic
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_rdwt_d  = mem_rdwt_q;
    mem_wdata_d = mem_wdata_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    armed_d     = (state_q == WB_WAIT) ||
                  (state_q == FILL_WAIT);
    line_we     = 1'b0;
    line_d      = cur_line;
    valid_set   = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req && !cpu_ready_q) begin
          wr_d    = bus.cpu_wr;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          cpu_ready_d = 1'b1;
          if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
          if (wr_q) begin
            line_we     = 1'b1;
            line_d      = put_word(cur_line, req_off, wdata_q);
            dirty_set   = 1'b1;
            cpu_rdata_d = wdata_q;
          end else begin
            cpu_rdata_d = get_word(cur_line, req_off);
          end
          state_d = IDLE;
        end else begin
          if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          if (valid_q[req_idx] && dirty_q[req_idx])
            state_d = WB_ISSUE;
          else
            state_d = FILL_ISSUE;
        end
      end
      WB_ISSUE: begin
        mem_addr_d  = {cur_tag, req_idx, {OFFB{1'b0}}};
        mem_rdwt_d  = 1'b1;
        mem_wdata_d = cur_line;
        state_d     = WB_WAIT;
      end
      WB_WAIT: begin
        if (succ) begin
          dirty_clr = 1'b1;
          state_d   = FILL_ISSUE;
        end
      end
      FILL_ISSUE: begin
        mem_addr_d = {req_tag, req_idx, {OFFB{1'b0}}};
        mem_rdwt_d = 1'b0;
        state_d    = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (succ) begin
          line_we   = 1'b1;
          valid_set = 1'b1;
          if (wr_q) begin
            line_d    = put_word(bus.mem_rdata, req_off, wdata_q);
            dirty_set = 1'b1;
          end else begin
            line_d    = bus.mem_rdata;
            dirty_clr = 1'b1;
          end
          cpu_ready_d = 1'b1;
          cpu_rdata_d = get_word(line_d, req_off);
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control, request and bus registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_rdwt_q  <= 1'b0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_rdwt_q  <= mem_rdwt_d;
      mem_wdata_q <= mem_wdata_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      armed_q     <= armed_d;
    end
  end

  // Per-line valid and dirty state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_set) valid_q[req_idx] <= 1'b1;
      if (dirty_set) dirty_q[req_idx] <= 1'b1;
      else if (dirty_clr) dirty_q[req_idx] <= 1'b0;
    end
  end

  // Tag and data arrays; contents are qualified by valid_q
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[req_idx] <= line_d;
      tag_q[req_idx]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl with a timed memory model
// and a direct-mapped reference model of the cache.
module tb_l1_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  l1_cache_ctrl_if bus ();

  l1_cache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int D = 3;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rdata;
    int lat;
    int hits;
    int misses;
    int start;
  } cpu_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic        rdwt;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  logic [7:0] mem_arr [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    bit             v;
    bit             d;
    int             tag;
    logic [3:0][7:0] w;
  } line_t;

  line_t lines [16];
  int m_hits = 0;
  int m_misses = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      lines[i].v = 1'b0;
      lines[i].d = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  // Behavioural cache: predicts data, counters, latency, bus traffic
  task automatic model_access(input bit wr,
                              input logic [15:0] a,
                              input logic [7:0] wd,
                              input int st);
    int off, idx, tag, base, lat;
    cpu_exp_t e;
    mem_exp_t m;
    off = int'(a) % 4;
    idx = (int'(a) / 4) % 16;
    tag = int'(a) / 64;
    if (lines[idx].v && lines[idx].tag == tag) begin
      if (m_hits < 65535) m_hits++;
      lat = 2;
    end else begin
      if (m_misses < 65535) m_misses++;
      lat = D + 4;
      if (lines[idx].v && lines[idx].d) begin
        base = (lines[idx].tag * 16 + idx) * 4;
        for (int k = 0; k < 4; k++)
          ref_mem[16'(base + k)] = lines[idx].w[k];
        m.addr = 16'(base);
        m.rdwt = 1'b1;
        m.wdata = lines[idx].w;
        mem_q.push_back(m);
        lat = 2 * D + 6;
      end
      base = (tag * 16 + idx) * 4;
      for (int k = 0; k < 4; k++)
        lines[idx].w[k] = ref_mem[16'(base + k)];
      m.addr = 16'(base);
      m.rdwt = 1'b0;
      m.wdata = '0;
      mem_q.push_back(m);
      lines[idx].v = 1'b1;
      lines[idx].d = 1'b0;
      lines[idx].tag = tag;
    end
    if (wr) begin
      lines[idx].w[off] = wd;
      lines[idx].d = 1'b1;
    end
    e.rdata = lines[idx].w[off];
    e.lat = lat;
    e.hits = m_hits;
    e.misses = m_misses;
    e.start = st;
    cpu_q.push_back(e);
  endtask

  task automatic mem_seen(input logic [15:0] a,
                          input logic r,
                          input logic [31:0] wd);
    mem_exp_t m;
    if (a == 16'h0 && !r) return;
    if (mem_q.size() == 0) begin
      chk("mem_unexpected", {15'h0, r, a}, 32'h0);
    end else begin
      m = mem_q.pop_front();
      chk("mem_addr", {16'h0, a}, {16'h0, m.addr});
      chk("mem_rdwt", {31'h0, r}, {31'h0, m.rdwt});
      if (m.rdwt) chk("mem_wdata", wd, m.wdata);
    end
    if (r)
      for (int k = 0; k < 4; k++)
        mem_arr[16'(a + k)] = wd[k*8 +: 8];
  endtask

  // Memory: success D cycles after a stable request, old value
  // lingers for one cycle after the request changes
  initial begin : mem_env
    logic [48:0] cur;
    logic [48:0] last;
    int cnt;
    bit done;
    bus.mem_success = 1'b0;
    bus.mem_rdata = '0;
    last = '1;
    cnt = 0;
    done = 1'b1;
    forever begin
      @(negedge clk);
      cur = {bus.mem_addr, bus.mem_rdwt, bus.mem_wdata};
      if (cur !== last) begin
        last = cur;
        cnt = 0;
        done = 1'b0;
      end else begin
        if (cnt < 100000) cnt++;
        if (cnt >= D) begin
          bus.mem_success = 1'b1;
          if (!done) begin
            done = 1'b1;
            mem_seen(bus.mem_addr, bus.mem_rdwt,
                     bus.mem_wdata);
          end
        end else begin
          bus.mem_success = 1'b0;
        end
      end
      for (int k = 0; k < 4; k++)
        bus.mem_rdata[k*8 +: 8] =
          mem_arr[16'(bus.mem_addr + 16'(k))];
    end
  end

  // CPU response monitor
  initial begin : cpu_mon
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cpu_ready) begin
        if (cpu_q.size() == 0) begin
          chk("cpu_unexpected", 32'h1, 32'h0);
        end else begin
          e = cpu_q.pop_front();
          chk("rdata", {24'h0, bus.cpu_rdata},
              {24'h0, e.rdata});
          chk("latency", cyc + 1 - e.start, e.lat);
          chk("hit_count", {16'h0, hit_count}, e.hits);
          chk("miss_count", {16'h0, miss_count}, e.misses);
        end
      end
    end
  end

  task automatic access(input bit wr,
                        input logic [15:0] a,
                        input logic [7:0] wd);
    int n;
    @(negedge clk);
    model_access(wr, a, wd, cyc + 1);
    bus.cpu_req = 1'b1;
    bus.cpu_wr = wr;
    bus.cpu_addr = a;
    bus.cpu_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ready && n < 300);
    if (!bus.cpu_ready) begin
      chk("ready_timeout", 32'h0, 32'h1);
      cpu_q.delete();
      mem_q.delete();
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, bus.cpu_ready}, 32'h0);
    chk({tag, "_rdata"}, {24'h0, bus.cpu_rdata}, 32'h0);
    chk({tag, "_maddr"}, {16'h0, bus.mem_addr}, 32'h0);
    chk({tag, "_mrdwt"}, {31'h0, bus.mem_rdwt}, 32'h0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_hits"}, {16'h0, hit_count}, 32'h0);
    chk({tag, "_misses"}, {16'h0, miss_count}, 32'h0);
  endtask

  initial begin : stim
    int n;
    logic [7:0] b;
    logic [15:0] a;
    bus.cpu_req = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      mem_arr[i] = b;
      ref_mem[i] = b;
    end
    for (int k = 0; k < 4; k++) begin
      mem_arr[16'h10 + k] = 8'hA0 + 8'(k);
      ref_mem[16'h10 + k] = 8'hA0 + 8'(k);
    end
    model_reset();
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    D = 3;
    access(1'b0, 16'h0010, 8'h00);
    access(1'b0, 16'h0012, 8'h00);
    access(1'b1, 16'h0011, 8'h5C);
    access(1'b0, 16'h0111, 8'h00);
    access(1'b1, 16'h0020, 8'h77);
    D = 2;
    access(1'b0, 16'h0420, 8'h00);
    access(1'b0, 16'h0020, 8'h00);

    D = 4;
    access(1'b1, 16'h0030, 8'h11);
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = 16'h0430;
    n = 0;
    while (bus.mem_rdwt !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wb_started", {31'h0, bus.mem_rdwt}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwb");
    bus.cpu_req = 1'b0;
    cpu_q.delete();
    mem_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    D = 3;
    access(1'b0, 16'h0430, 8'h00);
    access(1'b0, 16'h0030, 8'h00);

    for (int i = 0; i < 150; i++) begin
      D = $urandom_range(1, 4);
      a = 16'(($urandom_range(1, 3) << 6) |
              ($urandom_range(0, 15) << 2) |
              $urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    repeat (10) @(negedge clk);
    chk("cpu_q_empty", cpu_q.size(), 32'h0);
    chk("mem_q_empty", mem_q.size(), 32'h0);
    chk("final_hits", {16'h0, hit_count}, m_hits);
    chk("final_misses", {16'h0, miss_count}, m_misses);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/l1_cache_ctrl.md
Name: l1_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller, one per core.
- Sits directly upstream of one port (A or B) of the block-level main memory.
- Accepts word-granular CPU reads and writes and converts misses into whole-block memory reads and writes using the memory's rdwt/access_success handshake.
- Two instances, one per memory port, form the dual-cache system.

Parameters:
- ADDRESSBIT, 16, byte address width, CPU and memory side.
- WORDSIZE, 8, bits per memory word (one addressable byte).
- BLOCKBYTE, 4, words per block; power of 2.
- NUMLINES, 16, cache lines; power of 2.
- Derived: OFFB = log2(BLOCKBYTE); IDXB = log2(NUMLINES); TAGB = ADDRESSBIT - IDXB - OFFB.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; held high until cpu_ready.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDRESSBIT  byte address.
- cpu_wdata  in  WORDSIZE  write data.
- cpu_rdata  out  WORDSIZE  read data; valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_addr  out  ADDRESSBIT  block-aligned byte address, low OFFB bits = 0.
- mem_rdwt  out  1  RD = 0, WT = 1.
- mem_wdata  out  BLOCKBYTE*WORDSIZE  writeback block; word k at [k*WORDSIZE +: WORDSIZE].
- mem_rdata  in  BLOCKBYTE*WORDSIZE  fill block, same packing.
- mem_success  in  1  memory access_success (1 = done, 0 = accessing).
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

Behaviour:
- Address split: tag = addr[ADDRESSBIT-1 -: TAGB], index = next IDXB bits, offset = low OFFB bits.
- Storage per line: valid, dirty, tag, data block.
- Reset (async, rst_n = 0):
  - All valid and dirty bits cleared; FSM goes to IDLE.
  - cpu_ready = 0, cpu_rdata = 0, mem_addr = 0, mem_rdwt = RD, mem_wdata = 0, counters = 0.
  - Any memory transaction in flight is abandoned; a partially issued writeback is lost by design.
- FSM states: IDLE, LOOKUP, WB_ISSUE, WB_WAIT, FILL_ISSUE, FILL_WAIT, RESP.
- IDLE: when cpu_req = 1 and cpu_ready = 0, latch wr/addr/wdata and go to LOOKUP.
- LOOKUP:
  - Hit (valid and tag match): read returns the word; write updates the word and sets dirty. Assert cpu_ready with cpu_rdata for one cycle, hit_count++, then IDLE.
  - Miss: miss_count++. Go to WB_ISSUE if the victim is valid and dirty, else FILL_ISSUE.
- WB_ISSUE: drive mem_addr = {victim tag, index, 0}, mem_rdwt = WT, mem_wdata = victim block; go to WB_WAIT. Memory-side outputs are registered.
- WB_WAIT: hold all memory outputs stable. mem_success is ignored in the first WB_WAIT cycle because it may be stale from the previous transaction. On a later cycle with mem_success = 1, clear dirty and go to FILL_ISSUE.
- FILL_ISSUE: drive mem_addr = {req tag, index, 0}, mem_rdwt = RD; go to FILL_WAIT.
- FILL_WAIT:
  - Same stale-success masking rule as WB_WAIT.
  - On mem_success = 1: install mem_rdata, set valid and tag.
  - For a write, merge cpu_wdata at the offset and set dirty; otherwise dirty = 0.
  - Go to RESP.
- RESP: cpu_ready = 1 for one cycle with the requested word (the merged word for a write); then IDLE.
- Memory-side outputs keep their last values while idle. The memory repeats an identical access, which is harmless.
- Memory request fields change only in the *_ISSUE states. The memory restarts its delay on any change, so mid-wait changes are forbidden.
- Hit latency: cpu_ready 2 cycles after cpu_req is first sampled.
- Miss latency, with the memory asserting success D cycles after a stable request:
  - Clean miss: D+4 cycles.
  - Dirty miss: 2D+6 cycles.
- Counters saturate at 16'hFFFF.
- Changing cpu_addr or cpu_wr while busy is a protocol violation; the latched request is used.
- No timeout: if mem_success never rises, the controller waits forever.

Test Plan:
- Reset, then read 0x0010, memory with D = 3 and block {A3,A2,A1,A0} → FILL read at mem_addr 0x0010; cpu_ready at cycle 7 with cpu_rdata = A0; miss_count = 1.
- Read 0x0012 immediately after → hit, cpu_ready 2 cycles later with rdata = A2, no memory activity, hit_count = 1.
- Write 0x0011 = 5C (hit), then read 0x0111 (same index, new tag) → WT to 0x0010 with block {A3,A2,5C,A0}, then RD to 0x0110; cpu_ready at 2D+6 = 12 cycles.
- Write miss to 0x0020 with data 77 → fill, word 0 becomes 77 and the line is dirty; a following conflicting read produces a writeback containing 77.
- Stale success: mem_success held at 1 from the prior access and dropping only one cycle after the new request → the controller does not complete early; completion waits for success to be re-asserted.
- rst_n pulsed low during WB_WAIT → all outputs return to their reset values at once; the next read to the same address is a miss.
